// File: rtl/accumulator_flexible_bitwidth_pkg.sv
// Shared constants for the flexible-bitwidth datapath blocks.
// Holds the width helper used to size counters/accumulators and the
// frame-accumulator state encodings.
package accumulator_flexible_bitwidth_pkg;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  typedef enum logic {
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/accumulator_flexible_bitwidth_if.sv
// Sample-in / frame-sum-out bus of the frame accumulator.
// Widths are derived from the same parameters as the accumulator itself,
// so both sides must be instantiated with matching WIDTH_IN / COUNT_N.
interface accumulator_flexible_bitwidth_if
  import accumulator_flexible_bitwidth_pkg::*;
#(
  parameter int WIDTH_IN = 9,
  parameter int COUNT_N  = 16
);
  localparam int WIDTH_CNT = clog2(COUNT_N + 1);
  localparam int WIDTH_ACC = WIDTH_IN + clog2(COUNT_N);

  logic                 clear;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_IN-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_ACC-1:0] out_sum;
  logic [WIDTH_CNT-1:0] out_count;

  // Producer of samples / consumer of frame sums.
  modport master (
    output clear, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  // The accumulator side.
  modport slave (
    input  clear, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/frame_sample_counter.sv
// Up-counter of samples within a frame, 0..COUNT_N-1.
// clr wins over en; term flags that the next increment completes a frame,
// so the owner can close the frame on the same edge and clear the count.
module frame_sample_counter
  import accumulator_flexible_bitwidth_pkg::*;
#(
  parameter int COUNT_N   = 16,
  parameter int WIDTH_CNT = clog2(COUNT_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [WIDTH_CNT-1:0] cnt,
  output logic                 term
);

  assign term = (cnt == WIDTH_CNT'(COUNT_N - 1));

  // Count enabled events; clear takes priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH_CNT'(1);
    end
  end

endmodule

// File: rtl/accumulator_flexible_bitwidth.sv
// Sums COUNT_N unsigned samples (or fewer on flush) into one widened frame sum.
// Frame sum appears one cycle after the closing sample is accepted.
// While a sum is held for the consumer, in_ready is low; clear aborts anything.
module accumulator_flexible_bitwidth
  import accumulator_flexible_bitwidth_pkg::*;
#(
  parameter int WIDTH_IN = 9,
  parameter int COUNT_N  = 16
) (
  input  logic                          clk,
  input  logic                          RST,
  accumulator_flexible_bitwidth_if.slave bus
);

  localparam int WIDTH_CNT = clog2(COUNT_N + 1);
  localparam int WIDTH_ACC = WIDTH_IN + clog2(COUNT_N);

  state_t               state;
  logic [WIDTH_ACC-1:0] acc;
  logic [WIDTH_ACC-1:0] acc_sum;
  logic                 out_valid_q;
  logic [WIDTH_ACC-1:0] out_sum_q;
  logic [WIDTH_CNT-1:0] out_count_q;

  logic                 in_ready;
  logic                 accept;
  logic [WIDTH_CNT-1:0] cnt;
  logic                 term;
  logic [WIDTH_CNT-1:0] close_cnt;
  logic                 frame_end;
  logic                 flush_close;
  logic                 close;

  // Ready is a pure state decode so it never combinationally follows in_valid.
  assign in_ready = (state == ACCUM);

  // A sample offered alongside clear is dropped even though ready is high.
  assign accept = bus.in_valid && in_ready && !bus.clear;

  // Count and sum as they would stand after this edge's sample, if any.
  assign close_cnt = cnt + WIDTH_CNT'(accept);
  assign acc_sum   = acc + (accept ? WIDTH_ACC'(bus.in_data) : '0);

  // Close on a full frame, or on flush if at least one sample is in it.
  assign frame_end   = accept && term;
  assign flush_close = (state == ACCUM) && bus.flush && !bus.clear &&
                       (close_cnt != '0);
  assign close       = frame_end || flush_close;

  frame_sample_counter #(
    .COUNT_N   (COUNT_N),
    .WIDTH_CNT (WIDTH_CNT)
  ) u_cnt (
    .clk  (clk),
    .rst  (RST),
    .clr  (bus.clear || close),
    .en   (accept),
    .cnt  (cnt),
    .term (term)
  );

  // Frame FSM with the running sum and the registered output frame.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= ACCUM;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else if (bus.clear) begin
      state       <= ACCUM;
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            out_sum_q   <= acc_sum;
            out_count_q <= close_cnt;
            out_valid_q <= 1'b1;
            acc         <= '0;
            state       <= HOLD;
          end else begin
            acc <= acc_sum;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_accumulator_flexible_bitwidth.sv
// Directed and randomized checks of the frame accumulator at COUNT_N = 4, 16, 1.
// Expected frames are queued when their samples are driven and compared
// when the corresponding output appears.
module tb_accumulator_flexible_bitwidth;

  logic clk;
  logic rst;

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  accumulator_flexible_bitwidth_if #(.WIDTH_IN(9), .COUNT_N(4))  b4 ();
  accumulator_flexible_bitwidth_if #(.WIDTH_IN(9), .COUNT_N(16)) b16 ();
  accumulator_flexible_bitwidth_if #(.WIDTH_IN(9), .COUNT_N(1))  b1 ();

  accumulator_flexible_bitwidth #(.WIDTH_IN(9), .COUNT_N(4))  dut4  (.clk(clk), .RST(rst), .bus(b4));
  accumulator_flexible_bitwidth #(.WIDTH_IN(9), .COUNT_N(16)) dut16 (.clk(clk), .RST(rst), .bus(b16));
  accumulator_flexible_bitwidth #(.WIDTH_IN(9), .COUNT_N(1))  dut1  (.clk(clk), .RST(rst), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int sum, input int cnt);
    exp_t e;
    e.sum = sum;
    e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
    exp_t e;
    chk({tag, "_pending"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_sum"}, sum, 32'(e.sum));
      chk({tag, "_cnt"}, cnt, 32'(e.cnt));
    end
  endtask

  initial begin
    int d4a[4];
    int acc_n;
    int cyc;
    logic v;
    logic r;
    logic [8:0] d;

    rst = 1'b1;
    b4.clear = 0;  b4.flush = 0;  b4.in_valid = 0;  b4.in_data = '0;  b4.out_ready = 0;
    b16.clear = 0; b16.flush = 0; b16.in_valid = 0; b16.in_data = '0; b16.out_ready = 0;
    b1.clear = 0;  b1.flush = 0;  b1.in_valid = 0;  b1.in_data = '0;  b1.out_ready = 0;
    #1;
    chk("rst_out_valid", b4.out_valid, 1'b0);
    chk("rst_out_sum",   b4.out_sum, '0);
    chk("rst_out_count", b4.out_count, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready4",  b4.in_ready, 1'b1);
    chk("rst_in_ready16", b16.in_ready, 1'b1);
    chk("rst_in_ready1",  b1.in_ready, 1'b1);
    chk("rst_out_valid16", b16.out_valid, 1'b0);

    // 1: four back-to-back samples, consumer always ready.
    d4a = '{10, 20, 30, 40};
    push_exp(100, 4);
    b4.out_ready = 1;
    foreach (d4a[i]) begin
      b4.in_valid = 1;
      b4.in_data  = 9'(d4a[i]);
      @(negedge clk);
      if (i < 3) chk("t1_no_early_out", b4.out_valid, 1'b0);
    end
    b4.in_valid = 0;
    chk("t1_latency", b4.out_valid, 1'b1);
    chk("t1_hold_not_ready", b4.in_ready, 1'b0);
    pop_chk("t1", b4.out_sum, b4.out_count);
    @(negedge clk);
    chk("t1_out_drop", b4.out_valid, 1'b0);
    chk("t1_ready_again", b4.in_ready, 1'b1);

    // 2: maximum samples, consumer stalls; 17th sample must wait.
    push_exp(8176, 16);
    b16.out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      b16.in_valid = 1;
      b16.in_data  = 9'd511;
      @(negedge clk);
    end
    pop_chk("t2_full", b16.out_sum, b16.out_count);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", b16.out_valid, 1'b1);
      chk("t2_hold_sum",   b16.out_sum, 32'd8176);
      chk("t2_hold_count", b16.out_count, 32'd16);
      chk("t2_hold_ready", b16.in_ready, 1'b0);
      @(negedge clk);
    end
    b16.in_valid  = 0;
    b16.out_ready = 1;
    @(negedge clk);
    chk("t2_release", b16.out_valid, 1'b0);
    push_exp(16, 16);
    for (int i = 0; i < 16; i++) begin
      b16.in_valid = 1;
      b16.in_data  = 9'd1;
      @(negedge clk);
      if (i < 15) chk("t2_second_no_early", b16.out_valid, 1'b0);
    end
    b16.in_valid = 0;
    chk("t2_second_valid", b16.out_valid, 1'b1);
    pop_chk("t2_second", b16.out_sum, b16.out_count);
    @(negedge clk);

    // 3: flush with a sample on the flush cycle, then an empty flush.
    push_exp(18, 3);
    b4.in_valid = 1; b4.in_data = 9'd5; @(negedge clk);
    b4.in_data = 9'd6; @(negedge clk);
    b4.in_data = 9'd7; b4.flush = 1; @(negedge clk);
    b4.in_valid = 0; b4.flush = 0;
    chk("t3_flush_valid", b4.out_valid, 1'b1);
    pop_chk("t3_flush", b4.out_sum, b4.out_count);
    @(negedge clk);
    chk("t3_flush_done", b4.out_valid, 1'b0);
    b4.flush = 1;
    @(negedge clk);
    b4.flush = 0;
    for (int k = 0; k < 2; k++) begin
      chk("t3_empty_flush", b4.out_valid, 1'b0);
      @(negedge clk);
    end

    // 4: clear discards partial frame and the sample offered with it.
    push_exp(10, 4);
    b4.in_valid = 1; b4.in_data = 9'd100; @(negedge clk);
    b4.in_data = 9'd200; @(negedge clk);
    b4.in_data = 9'd50; b4.clear = 1; @(negedge clk);
    b4.clear = 0;
    for (int i = 1; i <= 4; i++) begin
      b4.in_data = 9'(i);
      @(negedge clk);
      if (i < 4) chk("t4_no_early_out", b4.out_valid, 1'b0);
    end
    b4.in_valid = 0;
    chk("t4_valid", b4.out_valid, 1'b1);
    pop_chk("t4", b4.out_sum, b4.out_count);
    @(negedge clk);
    chk("t4_done", b4.out_valid, 1'b0);

    // 5: asynchronous reset while holding a frame.
    push_exp(100, 4);
    b4.out_ready = 0;
    foreach (d4a[i]) begin
      b4.in_valid = 1;
      b4.in_data  = 9'(d4a[i]);
      @(negedge clk);
    end
    b4.in_valid = 0;
    pop_chk("t5_before", b4.out_sum, b4.out_count);
    @(negedge clk);
    chk("t5_still_hold", b4.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", b4.out_valid, 1'b0);
    chk("t5_async_sum",   b4.out_sum, '0);
    chk("t5_async_count", b4.out_count, '0);
    @(negedge clk);
    rst = 1'b0;
    b4.out_ready = 1;
    chk("t5_ready", b4.in_ready, 1'b1);
    push_exp(10, 4);
    for (int i = 1; i <= 4; i++) begin
      b4.in_valid = 1;
      b4.in_data  = 9'(i);
      @(negedge clk);
    end
    b4.in_valid = 0;
    chk("t5_after_valid", b4.out_valid, 1'b1);
    pop_chk("t5_after", b4.out_sum, b4.out_count);
    @(negedge clk);

    // 6: COUNT_N=1 with random valid/ready over 200 accepted samples.
    acc_n = 0;
    cyc   = 0;
    while ((acc_n < 200 || sbq.size() != 0) && cyc < 5000) begin
      v = (acc_n < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = (acc_n < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      d = 9'($urandom_range(0, 511));
      b1.in_valid  = v;
      b1.in_data   = d;
      b1.out_ready = r;
      if (b1.out_valid && r) pop_chk("t6", b1.out_sum, b1.out_count);
      if (v && b1.in_ready) begin
        push_exp(int'(d), 1);
        acc_n++;
      end
      @(negedge clk);
      cyc++;
    end
    b1.in_valid = 0;
    chk("t6_accepted", 32'(acc_n), 32'd200);
    chk("t6_drained", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    chk("t6_idle", b1.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_flexible_bitwidth.md
Name: accumulator_flexible_bitwidth

Overview:
- Downstream consumer of the flexible-bitwidth adder: takes the adder's widened result as a stream of samples and accumulates COUNT_N of them into one frame sum.
- Output width grows so that overflow is impossible.
- Valid/ready handshake on input and output; a frame sum is held until the downstream stage accepts it.
- Supports early flush (partial frame) and synchronous clear.

Parameters:
- WIDTH_IN, 9, input sample width (default matches 8+8-bit adder output).
- COUNT_N, 16, samples per frame, at least 1.
- WIDTH_CNT (localparam), clog2(COUNT_N+1), sample-counter width.
- WIDTH_ACC (localparam), WIDTH_IN + clog2(COUNT_N), accumulator/output width (13 at defaults).

Ports:
- clk  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort of the current frame.
- flush  input  1  close the frame early with the samples gathered so far.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH_IN  unsigned sample (adder result).
- out_valid  output  1  out_sum/out_count are valid.
- out_ready  input  1  downstream accepts the output.
- out_sum  output  WIDTH_ACC  unsigned frame sum, registered.
- out_count  output  WIDTH_CNT  number of samples in out_sum (1..COUNT_N).

Behaviour:
- Reset (RST=1, asynchronous): state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0.
- After reset, in_ready=1 from the first clock edge.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- in_ready is a combinational decode of the state only; it never depends on in_valid.
- Accept: a sample is accepted when in_valid && in_ready at the clock edge. Then acc <= acc + zero-extended in_data and cnt <= cnt + 1.
- Frame end (ACCUM): when an accept makes cnt+1 == COUNT_N, in the same edge:
  - out_sum <= acc + in_data, out_count <= COUNT_N.
  - acc <= 0, cnt <= 0.
  - go to HOLD.
  - Latency: out_valid rises 1 cycle after the last sample is accepted.
- Flush (ACCUM, flush=1): the closing count is cnt + (accept ? 1 : 0).
  - If that count > 0: close the frame exactly as at frame end, with that count.
  - If that count = 0: ignored, no output.
  - A sample accepted on the flush cycle is included in the sum.
- flush in HOLD is ignored.
- HOLD: out_sum and out_count stay stable while out_valid && !out_ready. On out_ready=1, go to ACCUM at the next edge and out_valid drops. New samples are accepted only from the following cycle; there is no same-cycle bypass.
- clear: highest synchronous priority, in any state. acc=0, cnt=0, out_valid=0, state=ACCUM. Any sample offered in that cycle is discarded, even though in_ready=1. A pending HOLD output is dropped.
- Arithmetic: unsigned only. WIDTH_ACC guarantees that COUNT_N * (2^WIDTH_IN - 1) fits, so there is no saturation and no wrap.
- Counter: cnt never exceeds COUNT_N-1 in ACCUM.
- COUNT_N=1: every accepted sample goes straight to HOLD with out_count=1.
- X handling: in_data is ignored when in_valid=0.

Decomposition:
- Shared include (team constants file) holds:
  - constant function clog2, also needed by other flexible-width blocks;
  - ACCUM/HOLD state encodings, as localparams of 1 bit.
- One natural sub-module: frame_sample_counter, a parameterized up-counter with clear, enable and terminal-count flag, reused by later framing stages.
- The accumulator datapath stays in the top module.

Test Plan:
1. COUNT_N=4; send 10, 20, 30, 40 back-to-back with out_ready=1 -> one cycle after the 40 is accepted: out_valid=1, out_sum=100, out_count=4; then in_ready=1 again.
2. Defaults; 16 samples of 511, out_ready=0 for 5 cycles after frame end -> out_sum=8176, out_count=16 held stable for 5 cycles, in_ready=0 throughout; a 17th sample offered during HOLD is not consumed.
3. COUNT_N=4; send 5, 6, then 7 together with flush=1 -> out_sum=18, out_count=3. A flush with no samples and in_valid=0 -> no out_valid.
4. COUNT_N=4; send 100, 200, then clear together with in_valid (data 50), then send 1, 2, 3, 4 -> the only output is out_sum=10, out_count=4.
5. Assert RST asynchronously mid-cycle while in HOLD with out_sum=100 -> out_valid, out_sum and out_count go to 0 immediately, without waiting for clk; after release, in_ready=1 and the next 4-sample frame sums correctly.
6. COUNT_N=1; random in_valid and out_ready toggling over 200 samples -> every accepted sample appears exactly once, in order, with out_count=1; a scoreboard matches all sums.
